// File: rtl/result_serializer_if.sv
// rtl/result_serializer_if.sv - upstream word handshake between the ALU stage and the serializer
interface result_serializer_if;
    logic [8:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/result_serializer.sv
// rtl/result_serializer.sv - frames a 9-bit result as start, 9 data LSB-first, even parity, stop on tx
module result_serializer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    result_serializer_if.slave   up,
    output logic                 tx,
    output logic                 busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [3:0]  bit_idx, bit_nxt;
    logic [8:0]  sh, sh_nxt;
    logic        par, par_nxt;
    logic        tx_nxt;
    logic        period_end;

    assign period_end  = (cnt == LAST_CNT);
    assign up.in_ready = (state == IDLE) && reset_n;
    assign busy        = (state != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= '0;
            par     <= 1'b0;
            tx      <= 1'b1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
            sh      <= sh_nxt;
            par     <= par_nxt;
            tx      <= tx_nxt;
        end
    end

    // tx is loaded on the same edge that changes state or bit, so the line
    // never lags the period boundary by a cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 16'd1;
        bit_nxt   = bit_idx;
        sh_nxt    = sh;
        par_nxt   = par;
        tx_nxt    = tx;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                tx_nxt  = 1'b1;
                if (up.in_valid && up.in_ready) begin
                    state_nxt = START;
                    sh_nxt    = up.in_data;
                    par_nxt   = ^up.in_data;
                    tx_nxt    = 1'b0;
                end
            end
            START: begin
                if (period_end) begin
                    state_nxt = DATA;
                    cnt_nxt   = '0;
                    bit_nxt   = 4'd0;
                    tx_nxt    = sh[0];
                    sh_nxt    = sh >> 1;
                end
            end
            DATA: begin
                if (period_end) begin
                    cnt_nxt = '0;
                    if (bit_idx == 4'd8) begin
                        state_nxt = PARITY;
                        bit_nxt   = 4'd0;
                        tx_nxt    = par;
                    end else begin
                        bit_nxt = bit_idx + 4'd1;
                        tx_nxt  = sh[0];
                        sh_nxt  = sh >> 1;
                    end
                end
            end
            PARITY: begin
                if (period_end) begin
                    state_nxt = STOP;
                    cnt_nxt   = '0;
                    tx_nxt    = 1'b1;
                end
            end
            STOP: begin
                if (period_end) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    tx_nxt    = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                tx_nxt    = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_result_serializer.sv
// tb/tb_result_serializer.sv - directed bench with a frame-level model for result_serializer
module tb_result_serializer;
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    result_serializer_if bus0 ();
    result_serializer_if bus1 ();
    logic tx0, busy0, tx1, busy1;

    result_serializer #(.CLKS_PER_BIT(4)) dut0 (
        .clock(clock), .reset_n(reset_n), .up(bus0), .tx(tx0), .busy(busy0)
    );
    result_serializer #(.CLKS_PER_BIT(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .up(bus1), .tx(tx1), .busy(busy1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic get_tx(input int u);
        return (u == 0) ? tx0 : tx1;
    endfunction
    function automatic logic get_busy(input int u);
        return (u == 0) ? busy0 : busy1;
    endfunction
    function automatic logic get_ready(input int u);
        return (u == 0) ? bus0.in_ready : bus1.in_ready;
    endfunction

    task automatic drive(input int u, input logic v, input logic [8:0] d);
        if (u == 0) begin
            bus0.in_valid = v;
            bus0.in_data  = d;
        end else begin
            bus1.in_valid = v;
            bus1.in_data  = d;
        end
    endtask

    // Model: a frame is a 12-entry list of line levels, one per bit period;
    // ph counts edges since capture, -1 meaning the line is idle.
    int          cpb [2] = '{4, 1};
    int          ph  [2] = '{-1, -1};
    logic [11:0] frm [2];

    always @(posedge clock or negedge reset_n) begin
        logic       v;
        logic [8:0] d;
        if (!reset_n) begin
            ph[0] = -1;
            ph[1] = -1;
        end else begin
            for (int u = 0; u < 2; u++) begin
                v = (u == 0) ? bus0.in_valid : bus1.in_valid;
                d = (u == 0) ? bus0.in_data  : bus1.in_data;
                if (ph[u] >= 0) begin
                    ph[u]++;
                    if (ph[u] == 12 * cpb[u]) ph[u] = -1;
                end else if (v) begin
                    frm[u][0] = 1'b0;
                    for (int k = 0; k < 9; k++) frm[u][k+1] = d[k];
                    frm[u][10] = ^d;
                    frm[u][11] = 1'b1;
                    ph[u] = 0;
                end
            end
        end
    end

    always @(negedge clock) begin
        for (int u = 0; u < 2; u++) begin
            chk(u == 0 ? "model_tx0" : "model_tx1", 32'(get_tx(u)),
                32'((ph[u] < 0) ? 1'b1 : frm[u][ph[u] / cpb[u]]));
            chk(u == 0 ? "model_busy0" : "model_busy1", 32'(get_busy(u)), 32'(ph[u] >= 0));
            chk(u == 0 ? "model_ready0" : "model_ready1", 32'(get_ready(u)),
                32'((ph[u] < 0) && reset_n));
        end
    end

    task automatic capture(input int u, input logic [8:0] d);
        @(negedge clock);
        #1 drive(u, 1'b1, d);
        @(posedge clock);
        #1 drive(u, 1'b0, d);
    endtask

    // exp lists line levels in transmit order, leftmost bit first.
    task automatic check_frame(input int u, input logic [11:0] exp, input int c);
        int bc = 0;
        for (int j = 0; j < 12 * c; j++) begin
            @(negedge clock);
            if (get_busy(u)) bc++;
            if (j % c == 0) chk("frame_bit", 32'(get_tx(u)), 32'(exp[11 - j / c]));
        end
        @(negedge clock);
        chk("end_ready", 32'(get_ready(u)), 32'd1);
        chk("end_busy", 32'(get_busy(u)), 32'd0);
        chk("end_tx", 32'(get_tx(u)), 32'd1);
        chk("busy_cycles", 32'(bc), 32'(12 * c));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 1'b0, 9'd0);
        drive(1, 1'b0, 9'd0);
        repeat (3) @(negedge clock);
        for (int u = 0; u < 2; u++) begin
            chk("rst_tx", 32'(get_tx(u)), 32'd1);
            chk("rst_busy", 32'(get_busy(u)), 32'd0);
            chk("rst_ready", 32'(get_ready(u)), 32'd0);
        end
        #1 reset_n = 1'b1;
        #1 chk("release_ready", 32'(bus0.in_ready), 32'd1);

        capture(0, 9'd11);
        check_frame(0, 12'b011010000011, 4);

        capture(0, 9'd0);
        check_frame(0, 12'b000000000001, 4);

        // back-to-back with in_valid held: second word taken on the edge after return to IDLE
        @(negedge clock);
        #1 drive(0, 1'b1, 9'd18);
        @(posedge clock);
        #1 drive(0, 1'b1, 9'd511);
        check_frame(0, 12'b001001000001, 4);
        @(posedge clock);
        #1 drive(0, 1'b0, 9'd0);
        check_frame(0, 12'b011111111111, 4);

        // input churn during a frame must not disturb the captured word
        capture(0, 9'h0A5);
        #0 drive(0, 1'b1, 9'h0A5);
        fork
            check_frame(0, 12'b010100101001, 4);
            begin
                for (int j = 0; j < 48; j++) begin
                    @(negedge clock);
                    #1;
                    if (j == 47) drive(0, 1'b0, 9'd0);
                    else         drive(0, 1'b1, 9'($urandom));
                end
            end
        join

        capture(1, 9'd256);
        check_frame(1, 12'b000000000111, 1);

        // reset in the middle of data bit 4
        capture(0, 9'd11);
        repeat (21) @(negedge clock);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_tx", 32'(tx0), 32'd1);
        chk("midrst_busy", 32'(busy0), 32'd0);
        chk("midrst_ready", 32'(bus0.in_ready), 32'd0);
        repeat (3) @(negedge clock);
        #1 reset_n = 1'b1;
        #1 chk("rerelease_ready", 32'(bus0.in_ready), 32'd1);
        for (int j = 0; j < 8; j++) begin
            @(negedge clock);
            chk("post_rst_tx", 32'(tx0), 32'd1);
            chk("post_rst_busy", 32'(busy0), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/result_serializer.md
RESULT_SERIALIZER -- requirements
Module: result_serializer

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, default 4, clock cycles per serial bit period; legal range 1..65535.
REQ-002 SHALL have port: clock  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_data  input  9  result word from the upstream ALU stage.
REQ-005 SHALL have port: in_valid  input  1  in_data is valid this cycle.
REQ-006 SHALL have port: in_ready  output  1  block can accept a word this cycle.
REQ-007 SHALL have port: tx  output  1  serial line, idle high, registered.
REQ-008 SHALL have port: busy  output  1  frame in progress.

Function
REQ-009 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-010 SHALL drive in_ready = 1 only in IDLE with reset_n high; 0 in every other state.
REQ-011 SHALL capture in_data into a 9-bit shift register at a rising edge where in_valid and in_ready are both 1, and move IDLE -> START at that edge.
REQ-012 SHALL ignore in_data and in_valid whenever in_ready is 0; upstream may change in_data freely then.
REQ-013 SHALL compute parity at capture as even parity: XOR of all 9 captured bits; tx = that XOR during PARITY.
REQ-014 SHALL hold each bit for exactly CLKS_PER_BIT cycles using a 16-bit period counter, cleared on every state or bit change.
REQ-015 SHALL send frame: START (tx=0), DATA 9 bits LSB-first, PARITY, STOP (tx=1); 12 bit periods total.
REQ-016 SHALL use a 4-bit bit index in DATA, 0..8; DATA -> PARITY after bit 8's period ends.
REQ-017 SHALL set tx at the same edge as the state/bit change, so tx changes exactly at the capture edge and every CLKS_PER_BIT edges after it.
REQ-018 SHALL move STOP -> IDLE exactly 12*CLKS_PER_BIT edges after capture; in_ready SHALL be 1 from that edge on.
REQ-019 SHALL hold tx = 1 in IDLE; no back-to-back overlap; the next capture can happen no earlier than the edge after return to IDLE.
REQ-020 SHALL drive busy = 1 in all states except IDLE.
REQ-021 SHALL treat bit 8 of in_data like any other data bit (no truncation; full 9-bit range 0..511 transmitted).
REQ-022 SHALL, with CLKS_PER_BIT = 1, still emit the full 12-cycle frame with no skipped or doubled bit.

Reset
REQ-023 SHALL, while reset_n = 0, force state IDLE, tx = 1, busy = 0, in_ready = 0, counters and shift register = 0, with no clock edge needed.
REQ-024 SHALL abandon a frame on reset mid-frame; tx returns high immediately, and no partial frame resumes after release.
REQ-025 SHALL set in_ready = 1 immediately when reset_n rises; capture is possible at the first rising edge after release.

Verification (CLKS_PER_BIT = 4 unless stated)
REQ-026 SHALL cover: capture 9'd11 -> tx per 4-cycle period: 0, 1,1,0,1,0,0,0,0,0, parity 1, stop 1; busy high 48 cycles; in_ready high at capture edge +48.
REQ-027 SHALL cover: capture 9'd18 then 9'd511 with in_valid held high -> frame 1 data 0,1,0,0,1,0,0,0,0 with parity 0; second capture on the first edge in IDLE; data all 1s, parity 1.
REQ-028 SHALL cover: in_valid high with in_data changing every cycle during a frame -> transmitted frame matches the originally captured word; no extra capture.
REQ-029 SHALL cover: reset_n low 3 cycles during DATA bit 4 -> tx = 1, busy = 0 asynchronously; after release, tx stays 1 until the next capture.
REQ-030 SHALL cover: CLKS_PER_BIT = 1, capture 9'd256 -> tx = 0,0,0,0,0,0,0,0,0,1,1,1 on 12 consecutive cycles, then IDLE.
REQ-031 SHALL cover: capture 9'd0 -> parity 0; frame is start, nine 0s, parity 0, then stop 1.
